// File: rtl/vc_allocator.sv
// Virtual-channel allocator for one router output port: round-robin grant of the
// lowest free downstream VC to an eligible head-flit requester, with ownership tracking.
module vc_allocator #(
  parameter int NUM_OF_INPUT_PORTS      = 4,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  localparam int PORT_W = (NUM_OF_INPUT_PORTS > 1) ? $clog2(NUM_OF_INPUT_PORTS) : 1,
  localparam int VC_W   = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_OF_INPUT_PORTS-1:0]               req_i,
  input  logic [NUM_OF_INPUT_PORTS-1:0]               release_i,
  output logic [NUM_OF_INPUT_PORTS-1:0]               grant_o,
  output logic [VC_W-1:0]                             grant_vc_o,
  output logic [NUM_OF_VIRTUAL_CHANNELS-1:0]          vc_busy_o,
  output logic [NUM_OF_VIRTUAL_CHANNELS*PORT_W-1:0]   vc_owner_o,
  output logic                                        alloc_error_o
);

  localparam int N = NUM_OF_INPUT_PORTS;
  localparam int V = NUM_OF_VIRTUAL_CHANNELS;

  logic [V-1:0]      busy_q, busy_d;
  logic [PORT_W-1:0] owner_q [V];
  logic [PORT_W-1:0] owner_d [V];
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [VC_W-1:0]   grant_vc_q, grant_vc_d;
  logic              err_q, err_d;

  logic [N-1:0]      owns, elig;
  logic              win_found, vc_found;
  logic [PORT_W-1:0] win;
  logic [VC_W-1:0]   free_vc;

  // Ownership and eligibility use only pre-edge state, so a VC freed this cycle is invisible.
  always_comb begin
    owns = '0;
    for (int p = 0; p < N; p++) begin
      for (int v = 0; v < V; v++) begin
        if (busy_q[v] && owner_q[v] == PORT_W'(p)) owns[p] = 1'b1;
      end
    end
    elig = req_i & ~owns;
  end

  always_comb begin
    int idx;
    idx       = 0;
    vc_found  = 1'b0;
    free_vc   = '0;
    for (int v = V - 1; v >= 0; v--) begin
      if (!busy_q[v]) begin
        vc_found = 1'b1;
        free_vc  = VC_W'(v);
      end
    end
    win_found = 1'b0;
    win       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (elig[idx]) begin
        win_found = 1'b1;
        win       = PORT_W'(idx);
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = '0;
    grant_vc_d = '0;
    err_d      = err_q;
    for (int p = 0; p < N; p++) begin
      if (release_i[p]) begin
        if (owns[p]) begin
          for (int v = 0; v < V; v++) begin
            if (busy_q[v] && owner_q[v] == PORT_W'(p)) begin
              busy_d[v]  = 1'b0;
              owner_d[v] = '0;
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
    // The granted VC was free pre-edge, so it never collides with a release above.
    if (win_found && vc_found) begin
      busy_d[free_vc]  = 1'b1;
      owner_d[free_vc] = win;
      grant_d[win]     = 1'b1;
      grant_vc_d       = free_vc;
      rr_ptr_d         = PORT_W'((int'(win) + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      for (int v = 0; v < V; v++) owner_q[v] <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_vc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_vc_q <= grant_vc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    vc_owner_o = '0;
    for (int v = 0; v < V; v++) vc_owner_o[v*PORT_W +: PORT_W] = owner_q[v];
  end

  assign grant_o       = grant_q;
  assign grant_vc_o    = grant_vc_q;
  assign vc_busy_o     = busy_q;
  assign alloc_error_o = err_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator (4 ports, 2 VCs): directed vector table, reset/corner
// sequences, then random traffic against a port-to-VC ownership model.
module tb_vc_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i, release_i, grant_o;
  logic       grant_vc_o;
  logic [1:0] vc_busy_o;
  logic [3:0] vc_owner_o;
  logic       alloc_error_o;

  int n_checks = 0;
  int n_fail   = 0;

  vc_allocator #(.NUM_OF_INPUT_PORTS(4), .NUM_OF_VIRTUAL_CHANNELS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .release_i(release_i),
    .grant_o(grant_o), .grant_vc_o(grant_vc_o), .vc_busy_o(vc_busy_o),
    .vc_owner_o(vc_owner_o), .alloc_error_o(alloc_error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic       vc;
    logic [1:0] busy;
    logic [3:0] owner;
    logic       err;
  } vec_t;

  vec_t tbl[18];

  // Model: owner port per VC (-1 = free), round-robin start, sticky error.
  int owner_port[2];
  int rr;
  bit err_m;
  logic [3:0] e_grant;
  logic       e_vc;
  logic [1:0] e_busy;
  logic [3:0] e_owner;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic vc,
                           input logic [1:0] b, input logic [3:0] o, input logic e);
    check({tag, ".grant"},    32'(grant_o),       32'(g));
    check({tag, ".grant_vc"}, 32'(grant_vc_o),    32'(vc));
    check({tag, ".vc_busy"},  32'(vc_busy_o),     32'(b));
    check({tag, ".vc_owner"}, 32'(vc_owner_o),    32'(o));
    check({tag, ".error"},    32'(alloc_error_o), 32'(e));
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] rl);
    req_i     = rq;
    release_i = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = '0;
    release_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] rq, input logic [3:0] rl);
    int vc_of[4];
    int w, fv;
    for (int p = 0; p < 4; p++) vc_of[p] = -1;
    for (int v = 0; v < 2; v++) if (owner_port[v] >= 0) vc_of[owner_port[v]] = v;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (rr + k) % 4;
      if (w < 0 && rq[p] && vc_of[p] < 0) w = p;
    end
    fv = -1;
    for (int v = 0; v < 2; v++) if (fv < 0 && owner_port[v] < 0) fv = v;
    for (int p = 0; p < 4; p++) begin
      if (rl[p]) begin
        if (vc_of[p] >= 0) owner_port[vc_of[p]] = -1;
        else err_m = 1'b1;
      end
    end
    e_grant = '0;
    e_vc    = 1'b0;
    if (w >= 0 && fv >= 0) begin
      owner_port[fv] = w;
      rr      = (w + 1) % 4;
      e_grant = 4'(1 << w);
      e_vc    = fv[0];
    end
    e_busy  = '0;
    e_owner = '0;
    for (int v = 0; v < 2; v++) begin
      if (owner_port[v] >= 0) begin
        e_busy[v] = 1'b1;
        e_owner[v*2 +: 2] = owner_port[v][1:0];
      end
    end
  endtask

  initial begin
    //              req      rel      grant    vc    busy   owner    err
    tbl[0]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 2'b01, 4'b0001, 1'b0}; // single request
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b01, 4'b0001, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'b11, 4'b1001, 1'b0};
    tbl[3]  = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 2'b11, 4'b1001, 1'b0}; // all busy
    tbl[4]  = '{4'b1000, 4'b0010, 4'b0000, 1'b0, 2'b10, 4'b1000, 1'b0}; // freed VC not yet grantable
    tbl[5]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 2'b11, 4'b1011, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 2'b01, 4'b0011, 1'b0};
    tbl[7]  = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0110, 4'b0000, 4'b0010, 1'b0, 2'b01, 4'b0001, 1'b0}; // contention
    tbl[9]  = '{4'b0110, 4'b0000, 4'b0100, 1'b1, 2'b11, 4'b1001, 1'b0};
    tbl[10] = '{4'b0000, 4'b0110, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0};
    tbl[11] = '{4'b1001, 4'b0000, 4'b1000, 1'b0, 2'b01, 4'b0011, 1'b0}; // wrap from 3
    tbl[12] = '{4'b1001, 4'b0000, 4'b0001, 1'b1, 2'b11, 4'b0011, 1'b0};
    tbl[13] = '{4'b0000, 4'b1001, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b0};
    tbl[14] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01, 4'b0000, 1'b0};
    tbl[15] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 2'b01, 4'b0000, 1'b1}; // release without ownership
    tbl[16] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b1}; // release+req same cycle
    tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b1};

    rst_n = 1'b0;
    req_i = '0;
    release_i = '0;
    #1;
    check_all("reset", 4'b0, 1'b0, 2'b00, 4'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].rel);
      check_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].vc, tbl[i].busy,
                tbl[i].owner, tbl[i].err);
    end

    // Fill both VCs (round-robin now at 3), then reset asynchronously mid-cycle.
    step(4'b0110, 4'b0000);
    step(4'b0110, 4'b0000);
    check_all("prefill", 4'b0100, 1'b1, 2'b11, 4'b1001, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'b0, 1'b0, 2'b00, 4'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // A pointer left at 3 would pick port 3; after reset port 0 must win.
    step(4'b1001, 4'b0000);
    check_all("rr_after_reset", 4'b0001, 1'b0, 2'b01, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000);
    check("grant_pulse", 32'(grant_o), 32'd0);

    do_reset();
    owner_port[0] = -1;
    owner_port[1] = -1;
    rr    = 0;
    err_m = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rq, rl;
      rq = 4'($urandom_range(15));
      rl = '0;
      for (int v = 0; v < 2; v++)
        if (owner_port[v] >= 0 && $urandom_range(2) == 0) rl[owner_port[v]] = 1'b1;
      if (c > 200 && $urandom_range(80) == 0) begin
        int p;
        p = $urandom_range(3);
        if (owner_port[0] != p && owner_port[1] != p) rl[p] = 1'b1;
      end
      model_step(rq, rl);
      step(rq, rl);
      check_all($sformatf("rand%0d", c), e_grant, e_vc, e_busy, e_owner, err_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_allocator.md
# vc_allocator

Virtual-channel allocator for one output port of a spidergon router node. Input ports holding a head flit (HEAD_FLIT 2'b01 or single-flit HEADER 2'b11) request a VC on the downstream link. The block grants free VCs round-robin across input ports and tracks VC ownership. A VC is freed when its owner signals that the packet's last flit (TAIL_FLIT 2'b00 or HEADER) has left. One instance sits per output port (local, clockwise, anti-clockwise, across) inside each node of spidergon_top.

## Interface
- NUM_OF_INPUT_PORTS, 4, number of requesting input ports (local, clockwise, anti-clockwise, across).
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs on the downstream link; must be ≥1.
- PORT_W, $clog2(NUM_OF_INPUT_PORTS) (min 1), derived local param.
- VC_W, $clog2(NUM_OF_VIRTUAL_CHANNELS) (min 1), derived local param.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- req  input  NUM_OF_INPUT_PORTS  bit i: input port i holds a head flit routed to this output.
- release  input  NUM_OF_INPUT_PORTS  bit i: 1-cycle pulse, port i has sent the last flit of its packet.
- grant  output  NUM_OF_INPUT_PORTS  registered, one-hot or zero; 1-cycle pulse for the winning port.
- grant_vc  output  VC_W  VC index accompanying grant; 0 when grant is 0.
- vc_busy  output  NUM_OF_VIRTUAL_CHANNELS  bit v: VC v is allocated.
- vc_owner  output  NUM_OF_VIRTUAL_CHANNELS*PORT_W  owner port of VC v at [v*PORT_W +: PORT_W]; 0 when free.
- alloc_error  output  1  sticky; set by a protocol violation, cleared only by reset.

## Operation
- State per VC: busy bit and owner index. Round-robin pointer rr_ptr (PORT_W bits). Sticky error flag.
- Eligible requester: req[i]=1 AND port i owns no VC. Ownership is evaluated on pre-edge state.
- Each cycle, if at least one eligible requester exists and at least one VC is free:
  - Winner: the first eligible i scanning from rr_ptr upward, wrapping mod NUM_OF_INPUT_PORTS.
  - VC: the lowest-index free VC.
  - On the edge: vc_busy[v]<=1, vc_owner[v]<=i, grant<=one-hot(i), grant_vc<=v, rr_ptr<=(i+1) mod NUM_OF_INPUT_PORTS.
- At most one grant per cycle. rr_ptr changes only on a grant.
- Otherwise grant<=0 and grant_vc<=0.
- Release: release[i] clears the VC owned by port i (busy<=0, owner<=0) on the edge.
- Freed VCs are not grantable in the same cycle; they are first visible to allocation in the next cycle.
- release[i] and req[i] in the same cycle: the release is processed. The request is ineligible that cycle because port i still owns its VC pre-edge.
- Protocol violation: release[i] while port i owns no VC. Response: alloc_error<=1, no state change.
- req held by a port that already owns a VC is ignored silently. This is not an error.
- A requester keeps req high until it sees grant. It must drop req in the cycle after grant unless it has a new head flit queued behind a released VC.

## Timing
- Reset values (asynchronous): grant=0, grant_vc=0, vc_busy=0, vc_owner=0, alloc_error=0, rr_ptr=0.
- Allocation latency: req sampled at edge t produces grant/grant_vc valid in the cycle after edge t (1 cycle).
- VC reuse latency: release at edge t makes the VC grantable at edge t+1, so the new grant is visible after t+1.
- All VCs busy: requests wait with no grant and no state change. There is no timeout.
- Wrap-around: with rr_ptr = NUM_OF_INPUT_PORTS-1, the scan order is N-1, 0, 1, …
- Reset asserted mid-operation clears ownership immediately. In-flight grants are lost; upstream logic is reset together with this block.

## Test plan
- Reset: drive reset=0 mid-run with vc_busy=2'b11 -> all outputs 0 immediately, without waiting for a clock; rr_ptr=0 on release of reset.
- Single request: req=4'b0010 for one cycle -> next cycle grant=4'b0010, grant_vc=0, vc_busy=2'b01, vc_owner[0]=1; rr_ptr=2.
- Contention: req=4'b0110 held, rr_ptr=0 -> cycle 1: grant port 1 on VC0; cycle 2: grant port 2 on VC1; vc_busy=2'b11; rr_ptr=3.
- Exhaustion and release: both VCs busy (ports 1, 2), req[3]=1 held, release=4'b0010 at edge k -> no grant after k; grant=4'b1000 with grant_vc=0 visible after k+1.
- Round-robin wrap: rr_ptr=3, req=4'b1001, 2 VCs free -> port 3 granted first (VC0), then port 0 (VC1); rr_ptr ends at 1.
- Error: release=4'b0100 while port 2 owns nothing -> alloc_error=1 next cycle, vc_busy and vc_owner unchanged; alloc_error stays 1 until reset.
